// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 FPGA output path: display FSM encoding and nibble width.
package sap1_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } disp_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (s_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/out_nibble_display.sv
// Buffers words written to the CPU output register and replays them on the user LEDs, MS nibble first.
//   state    | meaning
//   ST_IDLE  | LEDs dark; pops the next queued word when one is available
//   ST_SHOW  | one nibble on led; advances on dwell terminal count (auto) or step (manual)
//   ST_BLANK | LEDs dark for BLANK_CYCLES after the last nibble of a word
module out_nibble_display
  import sap1_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 5_000_000,
  parameter int CNT_WIDTH    = 26
) (
  input  logic                                  clk,
  input  logic                                  s_reset,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  input  logic                                  manual,
  input  logic                                  step,
  output logic [3:0]                            led,
  output logic [$clog2(DATA_WIDTH/4)-1:0]       nib_idx,
  output logic                                  showing,
  output logic                                  busy,
  output logic                                  fifo_full,
  output logic                                  overflow
);

  localparam int NIBBLES = DATA_WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  localparam logic [CNT_WIDTH-1:0] DWELL_LAST = CNT_WIDTH'(DWELL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] BLANK_LAST = CNT_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]     IDX_MSN    = IDX_W'(NIBBLES - 1);

  disp_state_t           state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [IDX_W-1:0]      idx_dn;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  advance;

  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign advance  = manual ? step : (cnt == DWELL_LAST);
  assign idx_dn   = nib_idx - 1'b1;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .s_reset (s_reset),
    .push    (wr_en),
    .pop     (fifo_pop),
    .wr_data (wr_data),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (s_reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      word_q   <= '0;
      nib_idx  <= '0;
      led      <= '0;
      showing  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full && !fifo_pop) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            word_q  <= fifo_rd_data;
            nib_idx <= IDX_MSN;
            cnt     <= '0;
            led     <= fifo_rd_data[DATA_WIDTH-1 -: NIBBLE_W];
            showing <= 1'b1;
            state   <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (advance) begin
            cnt <= '0;
            if (nib_idx != '0) begin
              nib_idx <= idx_dn;
              led     <= word_q[NIBBLE_W*idx_dn +: NIBBLE_W];
            end else begin
              led     <= '0;
              showing <= 1'b0;
              state   <= (BLANK_CYCLES > 0) ? ST_BLANK : ST_IDLE;
            end
          end else if (manual) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_nibble_display.sv
// Lockstep bench for out_nibble_display: a queue-based display model predicts every output each cycle.
module tb_out_nibble_display;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        s_reset, wr_en, manual, step;
  logic [15:0] wr_data;
  logic [3:0]  led;
  logic [1:0]  nib_idx;
  logic        showing, busy, fifo_full, overflow;

  logic        b_wr_en;
  logic [15:0] b_wr_data;
  logic [3:0]  b_led;
  logic [1:0]  b_nib_idx;
  logic        b_showing, b_busy, b_fifo_full, b_overflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  out_nibble_display #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .CNT_WIDTH(26)
  ) dut (
    .clk(clk), .s_reset(s_reset), .wr_en(wr_en), .wr_data(wr_data), .manual(manual), .step(step),
    .led(led), .nib_idx(nib_idx), .showing(showing), .busy(busy), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  out_nibble_display #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DWELL_CYCLES(DWELL), .BLANK_CYCLES(0), .CNT_WIDTH(26)
  ) dut_nb (
    .clk(clk), .s_reset(s_reset), .wr_en(b_wr_en), .wr_data(b_wr_data), .manual(1'b0), .step(1'b0),
    .led(b_led), .nib_idx(b_nib_idx), .showing(b_showing), .busy(b_busy), .fifo_full(b_fifo_full),
    .overflow(b_overflow)
  );

  // Reference model: queue of accepted words plus what is on the LEDs and for how long.
  logic [15:0] m_q[$];
  logic [15:0] m_word;
  int          m_mode;  // 0 dark/idle, 1 showing a nibble, 2 dark after word
  int          m_idx, m_t;
  bit          m_ovf, m_rst;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit adv;
    m_rst = s_reset;
    if (s_reset) begin
      m_q.delete();
      m_mode = 0; m_t = 0; m_idx = 0; m_ovf = 0; m_word = '0;
      return;
    end
    case (m_mode)
      0: if (m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_idx = DW/4 - 1; m_t = 0; m_mode = 1;
      end
      1: begin
        adv = manual ? step : (m_t == DWELL - 1);
        if (adv) begin
          m_t = 0;
          if (m_idx > 0) m_idx--;
          else m_mode = (BLANK > 0) ? 2 : 0;
        end else begin
          m_t = manual ? 0 : m_t + 1;
        end
      end
      default: if (m_t == BLANK - 1) begin m_mode = 0; m_t = 0; end else m_t++;
    endcase
    if (wr_en) begin
      if (m_q.size() < DEPTH) m_q.push_back(wr_data);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    logic [15:0] sh;
    sh = m_word >> (4 * m_idx);
    check_eq("led", {28'd0, led}, (m_mode == 1) ? {28'd0, sh[3:0]} : 32'd0);
    check_eq("showing", {31'd0, showing}, (m_mode == 1) ? 32'd1 : 32'd0);
    check_eq("busy", {31'd0, busy}, (m_q.size() > 0 || m_mode != 0) ? 32'd1 : 32'd0);
    check_eq("fifo_full", {31'd0, fifo_full}, (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    if (m_mode == 1 || m_rst) check_eq("nib_idx", {30'd0, nib_idx}, m_rst ? 32'd0 : m_idx);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic push_word(input logic [15:0] w);
    wr_en = 1'b1; wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    bit hit;
    s_reset = 1'b1; wr_en = 1'b0; wr_data = '0; manual = 1'b0; step = 1'b0;
    b_wr_en = 1'b0; b_wr_data = '0;
    m_q.delete(); m_mode = 0; m_t = 0; m_idx = 0; m_ovf = 0; m_word = '0; m_rst = 1;
    repeat (3) tick();
    s_reset = 1'b0;
    tick();

    // single word, auto dwell
    push_word(16'hA5C3);
    repeat (25) tick();

    // burst of six: one popped, four queued, last dropped
    for (int i = 0; i < 6; i++) push_word(16'($urandom));
    repeat (120) tick();

    // manual stepping
    manual = 1'b1;
    push_word(16'h1234);
    repeat (100) tick();
    for (int i = 0; i < 4; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      repeat (9) tick();
    end
    manual = 1'b0;
    repeat (5) tick();

    // reset mid-show with words queued
    push_word(16'hBEEF);
    push_word(16'h1111);
    push_word(16'h2222);
    repeat (6) tick();
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    repeat (30) tick();

    // push on the exact cycle IDLE pops from a full FIFO
    manual = 1'b1;
    for (int i = 0; i < 5; i++) push_word(16'($urandom));
    hit = 0;
    for (int k = 0; k < 60; k++) begin
      wr_en = (!hit && m_mode == 0 && m_q.size() == DEPTH);
      wr_data = 16'($urandom);
      if (wr_en) hit = 1;
      step = (k % 3 == 0);
      tick();
    end
    wr_en = 1'b0; step = 1'b0;
    check_eq("full_pop_push_hit", {31'd0, hit}, 32'd1);
    manual = 1'b0;
    repeat (150) tick();

    // random traffic
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      wr_en   = ($urandom_range(5) == 0);
      wr_data = 16'($urandom);
      step    = ($urandom_range(4) == 0);
      s_reset = ($urandom_range(799) == 0);
      if ($urandom_range(199) == 0) manual = ~manual;
      tick();
    end
    wr_en = 1'b0; step = 1'b0; s_reset = 1'b0; manual = 1'b0;

    // BLANK_CYCLES=0 instance: one dark IDLE cycle between words
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    b_wr_en = 1'b1; b_wr_data = 16'h0F0F; tick();
    b_wr_data = 16'hF0F0; tick();
    b_wr_en = 1'b0;
    check_eq("nb_first_show", {31'd0, b_showing}, 32'd1);
    check_eq("nb_first_msn", {28'd0, b_led}, 32'h0);
    repeat (15) tick();
    check_eq("nb_lsn_led", {28'd0, b_led}, 32'hF);
    check_eq("nb_lsn_idx", {30'd0, b_nib_idx}, 32'd0);
    tick();
    check_eq("nb_gap_led", {28'd0, b_led}, 32'h0);
    check_eq("nb_gap_showing", {31'd0, b_showing}, 32'd0);
    check_eq("nb_gap_busy", {31'd0, b_busy}, 32'd1);
    tick();
    check_eq("nb_w2_led", {28'd0, b_led}, 32'hF);
    check_eq("nb_w2_idx", {30'd0, b_nib_idx}, 32'd3);
    check_eq("nb_w2_showing", {31'd0, b_showing}, 32'd1);
    check_eq("nb_overflow", {31'd0, b_overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
